// File: rtl/cic_pkg.sv
// Shared parameters and types for the CIC decimator with droop-compensation FIR.
package cic_pkg;
    localparam int IN_W      = 5;
    localparam int N         = 5;
    localparam int R         = 64;
    localparam int LOG2R     = $clog2(R);
    localparam int OUT_W     = IN_W + N * LOG2R;
    localparam int ACC_W     = OUT_W + 4;
    localparam int FIR_TAPS  = 3;
    localparam int FIR_SHIFT = 3;
    // Tap 0 multiplies the newest CIC sample.
    localparam int FIR_COEF [FIR_TAPS] = '{-1, 10, -1};

    typedef logic signed [OUT_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Clamp a wide FIR result into the output range instead of letting it wrap.
    function automatic sample_t sat(input acc_t y);
        sample_t res;
        logic [ACC_W-OUT_W:0] top;
        top = y[ACC_W-1:OUT_W-1];
        if (top == '0 || top == '1) begin
            res = y[OUT_W-1:0];
        end else if (y[ACC_W-1]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return res;
    endfunction
endpackage

// File: rtl/cic_decim_comp_if.sv
// Sample-stream bundle between the ADC side and the decimated outputs.
interface cic_decim_comp_if;
    logic signed [cic_pkg::IN_W-1:0] dat_in;
    cic_pkg::sample_t                cic_dat_out;
    logic                            cic_vld_out;
    cic_pkg::sample_t                dat_out;
    logic                            clk_vld_out;

    modport master (
        output dat_in,
        input  cic_dat_out, cic_vld_out, dat_out, clk_vld_out
    );

    modport slave (
        input  dat_in,
        output cic_dat_out, cic_vld_out, dat_out, clk_vld_out
    );
endinterface

// File: rtl/cic_core.sv
// N-stage CIC decimator: full-rate integrators, decimation counter, decimated-rate combs.
module cic_core import cic_pkg::*; (
    input  logic                   clk,
    input  logic                   srst,
    input  logic signed [IN_W-1:0] dat_in,
    output sample_t                cic_dat_out,
    output logic                   cic_vld_out
);
    localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(R - 1);

    sample_t          integ [N];
    sample_t          comb_dly_reg [N];
    sample_t          comb_in [N];
    sample_t          comb_res;
    logic [LOG2R-1:0] cnt_reg;
    sample_t          cic_dat_reg;
    logic             cic_vld_reg;

    // Integrators wrap modulo 2^OUT_W; the combs undo the wrap exactly.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_integ
            sample_t acc_reg;
            sample_t addend;
            if (gi == 0) begin : g_first
                assign addend = sample_t'(dat_in);
            end else begin : g_rest
                assign addend = integ[gi-1];
            end
            always_ff @(posedge clk) begin
                if (srst) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_reg + addend;
                end
            end
            assign integ[gi] = acc_reg;
        end
    endgenerate

    always_comb begin
        comb_in = '{default: '0};
        comb_in[0] = integ[N-1];
        for (int k = 1; k < N; k++) begin
            comb_in[k] = comb_in[k-1] - comb_dly_reg[k-1];
        end
        comb_res = comb_in[N-1] - comb_dly_reg[N-1];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg     <= '0;
            cic_dat_reg <= '0;
            cic_vld_reg <= 1'b0;
            for (int k = 0; k < N; k++) begin
                comb_dly_reg[k] <= '0;
            end
        end else begin
            cnt_reg     <= cnt_reg + 1'b1;
            cic_vld_reg <= (cnt_reg == CNT_LAST);
            if (cnt_reg == CNT_LAST) begin
                for (int k = 0; k < N; k++) begin
                    comb_dly_reg[k] <= comb_in[k];
                end
                cic_dat_reg <= comb_res;
            end
        end
    end

    assign cic_dat_out = cic_dat_reg;
    assign cic_vld_out = cic_vld_reg;
endmodule

// File: rtl/cic_decim_comp.sv
// CIC decimator followed by a 3-tap sinc-droop compensator running on the CIC strobe.
module cic_decim_comp import cic_pkg::*; (
    input  logic              clk,
    input  logic              rstn,
    cic_decim_comp_if.slave   bus
);
    sample_t cic_dat;
    logic    cic_vld;
    sample_t taps [FIR_TAPS];
    acc_t    prod [FIR_TAPS];
    acc_t    acc_sum;
    acc_t    acc_shift;
    sample_t dat_reg;
    logic    vld_reg;

    cic_core u_core (
        .clk         (clk),
        .srst        (rstn),
        .dat_in      (bus.dat_in),
        .cic_dat_out (cic_dat),
        .cic_vld_out (cic_vld)
    );

    assign taps[0] = cic_dat;

    // Delay line advances only when a new decimated sample arrives.
    genvar gi;
    generate
        for (gi = 1; gi < FIR_TAPS; gi++) begin : g_tap
            sample_t dly_reg;
            always_ff @(posedge clk) begin
                if (rstn) begin
                    dly_reg <= '0;
                end else if (cic_vld) begin
                    dly_reg <= taps[gi-1];
                end
            end
            assign taps[gi] = dly_reg;
        end
        for (gi = 0; gi < FIR_TAPS; gi++) begin : g_prod
            assign prod[gi] = acc_t'(taps[gi]) * acc_t'(FIR_COEF[gi]);
        end
    endgenerate

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < FIR_TAPS; k++) begin
            acc_sum = acc_sum + prod[k];
        end
        acc_shift = acc_sum >>> FIR_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            dat_reg <= '0;
            vld_reg <= 1'b0;
        end else begin
            vld_reg <= cic_vld;
            if (cic_vld) begin
                dat_reg <= sat(acc_shift);
            end
        end
    end

    assign bus.cic_dat_out = cic_dat;
    assign bus.cic_vld_out = cic_vld;
    assign bus.dat_out     = dat_reg;
    assign bus.clk_vld_out = vld_reg;
endmodule

// File: tb/tb_cic_decim_comp.sv
// Bench for cic_decim_comp: CIC modelled as a convolution with its impulse response, FIR by formula.
module tb_cic_decim_comp;
    import cic_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    cic_decim_comp_if bus ();

    cic_decim_comp dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam int HLEN = N * (R - 1) + 1;

    int     checks = 0;
    int     errors = 0;
    int     tcount = 0;
    int     hist [0:65535];
    longint yv [0:1100];
    longint h [0:HLEN-1];
    longint exp_cic = 0;
    longint exp_dat = 0;
    bit     exp_cv = 1'b0;
    bit     exp_dv = 1'b0;

    function automatic longint wrap_out(input longint s);
        longint v;
        v = s & 64'h0000_0007_FFFF_FFFF;
        if (v >= 64'sd17179869184) v = v - 64'sd34359738368;
        return v;
    endfunction

    // Output m of the CIC equals the N-fold boxcar response applied to the input history.
    function automatic longint cic_ref(input int m);
        longint s = 0;
        for (int k = 0; k < HLEN; k++) begin
            int idx = R * m - N - k;
            if (idx >= 1) s += h[k] * longint'(hist[idx]);
        end
        return wrap_out(s);
    endfunction

    function automatic longint fir_ref(input longint y0, input longint y1, input longint y2);
        longint acc, q;
        longint hi, lo;
        hi = (longint'(1) <<< 34) - 1;
        lo = -(longint'(1) <<< 34);
        acc = 10 * y1 - y0 - y2;
        q = acc >>> 3;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    function automatic longint yv_at(input int m);
        return (m >= 1) ? yv[m] : 64'sd0;
    endfunction

    // Drives one clock and advances the reference model to the state after that edge.
    task automatic tick(input int x, input bit r);
        int m;
        bus.dat_in = x[IN_W-1:0];
        rstn = r;
        @(posedge clk);
        if (r) begin
            tcount = 0;
            exp_cic = 0; exp_dat = 0; exp_cv = 0; exp_dv = 0;
        end else begin
            tcount++;
            hist[tcount] = x;
            exp_cv = (tcount % R == 0);
            exp_dv = (tcount > R) && (tcount % R == 1);
            if (exp_cv) begin
                m = tcount / R;
                yv[m] = cic_ref(m);
                exp_cic = yv[m];
            end
            if (exp_dv) begin
                m = (tcount - 1) / R;
                exp_dat = fir_ref(yv_at(m), yv_at(m - 1), yv_at(m - 2));
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int first_c = -1;
        int first_d = -1;
        for (int i = 0; i < 3; i++) begin
            tick(7, 1'b1);
            checks++;
            if (bus.cic_vld_out !== 1'b0 || bus.clk_vld_out !== 1'b0 ||
                bus.cic_dat_out !== '0 || bus.dat_out !== '0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d cic=%0d vld=%0b dat=%0d dvld=%0b required all zero",
                         i, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out);
            end
        end
        for (int i = 0; i < 140; i++) begin
            tick(7, 1'b0);
            if (bus.cic_vld_out === 1'b1 && first_c < 0) first_c = tcount;
            if (bus.clk_vld_out === 1'b1 && first_d < 0) first_d = tcount;
            checks++;
            if (bus.cic_vld_out !== exp_cv || bus.clk_vld_out !== exp_dv ||
                bus.cic_dat_out !== sample_t'(exp_cic) || bus.dat_out !== sample_t'(exp_dat)) begin
                errors++;
                $display("FAIL reset_run t=%0d cic=%0d/%0b dat=%0d/%0b required cic=%0d/%0b dat=%0d/%0b",
                         tcount, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out,
                         exp_cic, exp_cv, exp_dat, exp_dv);
            end
            if (bus.clk_vld_out === 1'b1)
                $display("reset_run t=%0d cic=%0d dat=%0d", tcount, bus.cic_dat_out, bus.dat_out);
        end
        checks++;
        if (first_c != 64) begin
            errors++;
            $display("FAIL first_cic_strobe got=%0d required=64", first_c);
        end
        checks++;
        if (first_d != 65) begin
            errors++;
            $display("FAIL first_comp_strobe got=%0d required=65", first_d);
        end
    endtask

    task automatic test_const(input int x);
        int     last_c = -1;
        longint settle;
        settle = longint'(x) * (longint'(1) <<< 30);
        tick(x, 1'b1);
        for (int i = 0; i < R * 10; i++) begin
            tick(x, 1'b0);
            checks++;
            if (bus.cic_vld_out !== exp_cv || bus.clk_vld_out !== exp_dv ||
                bus.cic_dat_out !== sample_t'(exp_cic) || bus.dat_out !== sample_t'(exp_dat)) begin
                errors++;
                $display("FAIL const_run x=%0d t=%0d cic=%0d/%0b dat=%0d/%0b required cic=%0d/%0b dat=%0d/%0b",
                         x, tcount, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out,
                         exp_cic, exp_cv, exp_dat, exp_dv);
            end
            if (bus.cic_vld_out === 1'b1) begin
                if (last_c >= 0) begin
                    checks++;
                    if (tcount - last_c != R) begin
                        errors++;
                        $display("FAIL strobe_period x=%0d got=%0d required=%0d", x, tcount - last_c, R);
                    end
                end
                last_c = tcount;
            end
            if (bus.clk_vld_out === 1'b1)
                $display("const x=%0d t=%0d cic=%0d dat=%0d", x, tcount, bus.cic_dat_out, bus.dat_out);
        end
        checks++;
        if (bus.cic_dat_out !== sample_t'(settle)) begin
            errors++;
            $display("FAIL const_cic_settle x=%0d got=%0d required=%0d", x, bus.cic_dat_out, settle);
        end
        checks++;
        if (bus.dat_out !== sample_t'(settle)) begin
            errors++;
            $display("FAIL const_dat_settle x=%0d got=%0d required=%0d", x, bus.dat_out, settle);
        end
    endtask

    task automatic test_step();
        longint peak_got = -(longint'(1) <<< 40);
        longint peak_exp = -(longint'(1) <<< 40);
        int x;
        tick(-16, 1'b1);
        for (int i = 0; i < R * 28 + 2; i++) begin
            x = (i < R * 8) ? -16 : 15;
            tick(x, 1'b0);
            checks++;
            if (bus.cic_vld_out !== exp_cv || bus.clk_vld_out !== exp_dv ||
                bus.cic_dat_out !== sample_t'(exp_cic) || bus.dat_out !== sample_t'(exp_dat)) begin
                errors++;
                $display("FAIL step_run t=%0d cic=%0d/%0b dat=%0d/%0b required cic=%0d/%0b dat=%0d/%0b",
                         tcount, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out,
                         exp_cic, exp_cv, exp_dat, exp_dv);
            end
            if (longint'(bus.dat_out) > peak_got) peak_got = longint'(bus.dat_out);
            if (exp_dat > peak_exp) peak_exp = exp_dat;
            if (bus.clk_vld_out === 1'b1)
                $display("step t=%0d cic=%0d dat=%0d", tcount, bus.cic_dat_out, bus.dat_out);
        end
        checks++;
        if (peak_got != peak_exp) begin
            errors++;
            $display("FAIL step_peak got=%0d required=%0d", peak_got, peak_exp);
        end
        checks++;
        if (bus.dat_out !== sample_t'(64'sd16106127360)) begin
            errors++;
            $display("FAIL step_settle got=%0d required=16106127360", bus.dat_out);
        end
    endtask

    task automatic test_mid_reset();
        int first_c = -1;
        tick(0, 1'b1);
        for (int i = 0; i < R * 3 + 30; i++) begin
            tick(int'($urandom_range(0, 31)) - 16, 1'b0);
        end
        tick(5, 1'b1);
        checks++;
        if (bus.cic_vld_out !== 1'b0 || bus.clk_vld_out !== 1'b0 ||
            bus.cic_dat_out !== '0 || bus.dat_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_state cic=%0d vld=%0b dat=%0d dvld=%0b required all zero",
                     bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out);
        end
        for (int i = 0; i < 140; i++) begin
            tick(int'($urandom_range(0, 31)) - 16, 1'b0);
            if (bus.cic_vld_out === 1'b1 && first_c < 0) first_c = tcount;
            checks++;
            if (bus.cic_vld_out !== exp_cv || bus.clk_vld_out !== exp_dv ||
                bus.cic_dat_out !== sample_t'(exp_cic) || bus.dat_out !== sample_t'(exp_dat)) begin
                errors++;
                $display("FAIL mid_reset_run t=%0d cic=%0d/%0b dat=%0d/%0b required cic=%0d/%0b dat=%0d/%0b",
                         tcount, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out,
                         exp_cic, exp_cv, exp_dat, exp_dv);
            end
            if (bus.clk_vld_out === 1'b1)
                $display("mid_reset t=%0d cic=%0d dat=%0d", tcount, bus.cic_dat_out, bus.dat_out);
        end
        checks++;
        if (first_c != R) begin
            errors++;
            $display("FAIL mid_reset_first_strobe got=%0d required=%0d", first_c, R);
        end
    endtask

    task automatic test_random();
        tick(0, 1'b1);
        for (int i = 0; i < 30000; i++) begin
            tick(int'($urandom_range(0, 31)) - 16, 1'b0);
            checks++;
            if (bus.cic_vld_out !== exp_cv || bus.clk_vld_out !== exp_dv ||
                bus.cic_dat_out !== sample_t'(exp_cic) || bus.dat_out !== sample_t'(exp_dat)) begin
                errors++;
                $display("FAIL random_run t=%0d cic=%0d/%0b dat=%0d/%0b required cic=%0d/%0b dat=%0d/%0b",
                         tcount, bus.cic_dat_out, bus.cic_vld_out, bus.dat_out, bus.clk_vld_out,
                         exp_cic, exp_cv, exp_dat, exp_dv);
            end
            if (bus.clk_vld_out === 1'b1)
                $display("random t=%0d cic=%0d dat=%0d", tcount, bus.cic_dat_out, bus.dat_out);
        end
    endtask

    initial begin
        longint tmp [0:HLEN-1];
        int len;
        for (int k = 0; k < HLEN; k++) h[k] = 0;
        h[0] = 1;
        len = 1;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < HLEN; k++) begin
                tmp[k] = 0;
                for (int j = 0; j < R; j++) begin
                    if (k - j >= 0 && k - j < len) tmp[k] += h[k-j];
                end
            end
            for (int k = 0; k < HLEN; k++) h[k] = tmp[k];
            len = len + R - 1;
        end
        bus.dat_in = '0;

        test_reset();
        test_const(1);
        test_const(-16);
        test_const(15);
        test_step();
        test_mid_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
